scrambler_ctrl: RTL and testbench
=================================

Name: scrambler_ctrl

Overview:
Frame-level sequencer for the serial scrambler datapath. Accepts payload bytes over a valid/ready handshake. Seeds the LFSR at frame start, then serializes each byte LSB-first as one bit per clk3 while enabling the LFSR and the bit-XOR stage in lockstep. Sits between the byte source and the LFSR/serializer pair, and reports frame completion and underrun.

Parameters:
SEED_W, 7, LFSR seed/state width
DEF_SEED, 7'h5D, seed used when seed_sel=0
LEN_W, 16, width of the frame byte-count

Ports:
clk3  in  1  clock
rst  in  1  reset; synchronous, active-high; clock clk3
start  in  1  frame start pulse; sampled only in IDLE
frame_len  in  LEN_W  payload bytes in frame, sampled with start
seed_sel  in  1  1: use seed_in; 0: use DEF_SEED
seed_in  in  SEED_W  external seed, sampled with start
in_valid  in  1  byte source valid
in_data  in  8  payload byte
in_ready  out  1  byte accepted when in_valid && in_ready
lfsr_load  out  1  one-cycle seed load strobe to LFSR
lfsr_seed  out  SEED_W  seed value, valid while lfsr_load=1
lfsr_en  out  1  LFSR advance enable
ser_bit  out  1  current plaintext bit to the XOR stage
ser_en  out  1  ser_bit valid; equals lfsr_en
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last bit of a frame
err_underrun  out  1  sticky: source stalled mid-frame; cleared on an accepted start

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; counters 0; err_underrun=0.
- States: IDLE, LOAD, WAIT_BYTE, SHIFT, FIN.
- IDLE:
  - start=1 and frame_len!=0: latch frame_len into bytes_left, select the seed, clear err_underrun, go to LOAD.
  - start=1 and frame_len==0: go to FIN with no lfsr_load.
  - start is ignored in every non-IDLE state.
- LOAD: lfsr_load=1 for exactly one cycle with lfsr_seed driven; then go to WAIT_BYTE.
- WAIT_BYTE:
  - in_ready=1.
  - On handshake: capture in_data, bit_cnt=0, go to SHIFT.
  - lfsr_en=0 while waiting.
  - If WAIT_BYTE is entered after the first byte of the frame and in_valid=0 that cycle, set err_underrun.
- SHIFT:
  - ser_bit = byte_reg[bit_cnt]; ser_en = lfsr_en = 1 every cycle; bit_cnt increments.
  - At bit_cnt==7, bytes_left decrements, and:
    - bytes_left==1: go to FIN.
    - otherwise: assert in_ready in this same cycle. On handshake, load the new byte and stay in SHIFT with bit_cnt=0, giving a gapless bitstream. With no handshake, go to WAIT_BYTE.
- FIN: done=1 for one cycle; go to IDLE.
- Latency: start → lfsr_load is 1 cycle; a byte handshake → its bit0 on ser_bit is 1 cycle. Continuous frame of N bytes: done arrives 8N+3 cycles after start.
- bit_cnt is 3-bit and wraps 7→0; bytes_left never underflows (FIN is taken at 1).
- A byte is accepted only via handshake; in_data is ignored otherwise.
- rst mid-frame: next cycle IDLE, all outputs 0, no done, partial byte discarded.

Optional Feature:
SCR_ABORT_EN
- Defined:
  - Adds input abort (1 bit) and output aborted (1 bit).
  - abort=1 in any non-IDLE state forces IDLE next cycle, pulses aborted for one cycle, suppresses done, and leaves err_underrun unchanged.
  - abort in IDLE is ignored.
  - abort has priority over start and over handshakes in the same cycle.
- Undefined: ports absent; a frame ends only on completion or rst.

Decomposition:
- Shared package scr_pkg: FSM state encoding, DEF_SEED constant, SEED_W and LEN_W defaults; reused by the LFSR and top level.
- One natural sub-module, scr_bit_ser: byte register, bit_cnt, ser_bit mux, and the last-bit flag.
- The FSM and length counter stay in scrambler_ctrl.

Test Plan:
- rst, then start, frame_len=1, seed_sel=0, byte 8'hA5 → lfsr_load with lfsr_seed=7'h5D; ser_bit sequence 1,0,1,0,0,1,0,1; done 1 cycle after the last bit; err_underrun=0.
- frame_len=3, in_valid held high, bytes 8'h01/8'h80/8'hFF → 24 consecutive ser_en cycles with no gap; done at cycle 27 after start.
- frame_len=2, in_valid dropped for 5 cycles between the bytes → ser_en low for the gap; err_underrun=1 and sticky until the next start.
- frame_len=0 → done 1 cycle after start; no lfsr_load; ser_en never high.
- rst asserted at bit 4 of byte 2, then start with seed_sel=1, seed_in=7'h12 → outputs clear; new frame loads 7'h12 and begins at bit0.
- SCR_ABORT_EN: abort mid-SHIFT → aborted pulse, no done, IDLE next cycle; start ignored while busy.

Source files
------------

// File: rtl/scr_pkg.sv
// scr_pkg: shared definitions for the serial scrambler slice.
// Holds the frame sequencer state encoding and the default widths and seed
// used by the LFSR and by the scrambler_ctrl top level.
package scr_pkg;

  localparam int              SCR_SEED_W   = 7;
  localparam int              SCR_LEN_W    = 16;
  localparam logic [6:0]      SCR_DEF_SEED = 7'h5D;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_FIN   = 3'd4
  } scr_state_t;

endpackage

// File: rtl/scr_bit_ser.sv
// scr_bit_ser: byte-to-bit serializer for the scrambler sequencer.
// Holds the current payload byte and a 3-bit bit counter, presents the
// selected bit LSB-first, and flags the last two bit positions so the
// controller can request the next byte in time for a gapless stream.
// Ports:
//   clk3, rst    clock / synchronous active-high reset (bit counter only)
//   load         capture data and restart at bit 0 (wins over advance)
//   data[7:0]    payload byte to capture
//   advance      step to the next bit (wraps 7 -> 0)
//   active       gate for ser_bit; ser_bit reads 0 when inactive
//   ser_bit      current plaintext bit
//   last_bit     bit counter is at 7
//   near_last    bit counter is at 6
module scr_bit_ser (
  input  logic       clk3,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       advance,
  input  logic       active,
  output logic       ser_bit,
  output logic       last_bit,
  output logic       near_last
);

  logic [7:0] byte_reg;
  logic [2:0] bit_cnt;

  always_ff @(posedge clk3) begin
    if (load) begin
      byte_reg <= data;
    end
  end

  always_ff @(posedge clk3) begin
    if (rst) begin
      bit_cnt <= 3'd0;
    end else if (load) begin
      bit_cnt <= 3'd0;
    end else if (advance) begin
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Gated so a stale byte never leaks onto the line outside SHIFT.
  assign ser_bit   = active & byte_reg[bit_cnt];
  assign last_bit  = (bit_cnt == 3'd7);
  assign near_last = (bit_cnt == 3'd6);

endmodule

// File: rtl/scrambler_ctrl.sv
// scrambler_ctrl: frame-level sequencer for the serial scrambler datapath.
// Takes payload bytes over valid/ready, seeds the LFSR at frame start and
// then streams each byte LSB-first, one bit per clk3, with the LFSR and XOR
// stage enabled in lockstep. Reports frame completion and source underrun.
// Optional build macro SCR_ABORT_EN adds an abort input / aborted output.
// Ports:
//   clk3, rst            clock / synchronous active-high reset
//   start, frame_len     frame request and byte count (sampled in IDLE)
//   seed_sel, seed_in    seed choice: 1 = seed_in, 0 = DEF_SEED
//   in_valid, in_data    byte source; in_ready accepts a byte
//   lfsr_load, lfsr_seed one-cycle seed strobe and its value
//   lfsr_en, ser_bit, ser_en  bit stream and LFSR advance enable
//   busy, done           non-IDLE indicator and end-of-frame pulse
//   err_underrun         sticky source stall flag, cleared on start
//   abort, aborted       (SCR_ABORT_EN only) forced return to IDLE
module scrambler_ctrl
  import scr_pkg::*;
#(
  parameter int                SEED_W   = SCR_SEED_W,
  parameter logic [SEED_W-1:0] DEF_SEED = SCR_DEF_SEED,
  parameter int                LEN_W    = SCR_LEN_W
) (
  input  logic              clk3,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              seed_sel,
  input  logic [SEED_W-1:0] seed_in,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              lfsr_load,
  output logic [SEED_W-1:0] lfsr_seed,
  output logic              lfsr_en,
  output logic              ser_bit,
  output logic              ser_en,
  output logic              busy,
  output logic              done,
`ifdef SCR_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              err_underrun
);

  scr_state_t        state;
  logic [LEN_W-1:0]  bytes_left;
  logic [SEED_W-1:0] seed_reg;
  logic              shift_on;
  logic              abort_hit;
  logic              byte_take;
  logic              last_bit;
  logic              near_last;

`ifdef SCR_ABORT_EN
  assign abort_hit = abort && (state != ST_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // A byte is taken only on a real handshake; abort overrides it.
  assign byte_take = in_valid && in_ready && !abort_hit;

  always_ff @(posedge clk3) begin
    if (rst) begin
      state        <= ST_IDLE;
      bytes_left   <= '0;
      in_ready     <= 1'b0;
      lfsr_load    <= 1'b0;
      shift_on     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_underrun <= 1'b0;
`ifdef SCR_ABORT_EN
      aborted      <= 1'b0;
`endif
    end else if (abort_hit) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      lfsr_load <= 1'b0;
      shift_on  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SCR_ABORT_EN
      aborted   <= 1'b1;
`endif
    end else begin
      lfsr_load <= 1'b0;
      done      <= 1'b0;
`ifdef SCR_ABORT_EN
      aborted   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_underrun <= 1'b0;
            busy         <= 1'b1;
            if (frame_len != '0) begin
              bytes_left <= frame_len;
              lfsr_load  <= 1'b1;
              state      <= ST_LOAD;
            end else begin
              done  <= 1'b1;
              state <= ST_FIN;
            end
          end
        end
        ST_LOAD: begin
          in_ready <= 1'b1;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            shift_on <= 1'b1;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (last_bit) begin
            bytes_left <= bytes_left - LEN_W'(1);
            if (bytes_left == LEN_W'(1)) begin
              shift_on <= 1'b0;
              done     <= 1'b1;
              state    <= ST_FIN;
            end else if (in_valid) begin
              // Next byte handed over on the last bit: stream stays gapless.
              in_ready <= 1'b0;
            end else begin
              // Source missed the gapless slot; in_ready stays up in WAIT.
              shift_on     <= 1'b0;
              err_underrun <= 1'b1;
              state        <= ST_WAIT;
            end
          end else if (near_last && (bytes_left != LEN_W'(1))) begin
            // Raise ready so it is visible during bit 7 of this byte.
            in_ready <= 1'b1;
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk3) begin
    if ((state == ST_IDLE) && start) begin
      seed_reg <= seed_sel ? seed_in : DEF_SEED;
    end
  end

  assign lfsr_seed = lfsr_load ? seed_reg : '0;
  assign lfsr_en   = shift_on;
  assign ser_en    = shift_on;

  scr_bit_ser u_bit_ser (
    .clk3      (clk3),
    .rst       (rst),
    .load      (byte_take),
    .data      (in_data),
    .advance   (state == ST_SHIFT),
    .active    (shift_on),
    .ser_bit   (ser_bit),
    .last_bit  (last_bit),
    .near_last (near_last)
  );

endmodule

// File: tb/tb_scrambler_ctrl.sv
// tb_scrambler_ctrl: directed self-checking bench for scrambler_ctrl.
// Cycle s of a frame is the clock period following the s-th edge after start
// is driven; start is sampled on edge 1, so lfsr_load shows in cycle 1.
module tb_scrambler_ctrl;

  logic        clk3 = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] frame_len = '0;
  logic        seed_sel = 1'b0;
  logic [6:0]  seed_in = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        lfsr_load;
  logic [6:0]  lfsr_seed;
  logic        lfsr_en;
  logic        ser_bit;
  logic        ser_en;
  logic        busy;
  logic        done;
  logic        err_underrun;
`ifdef SCR_ABORT_EN
  logic        abort = 1'b0;
  logic        aborted;
`endif

  int checks = 0;
  int errors = 0;

  logic       en_log   [0:63];
  logic       bit_log  [0:63];
  logic       done_log [0:63];
  logic       load_log [0:63];
  logic [6:0] seed_log [0:63];
  logic       rdy_log  [0:63];
  logic       err_log  [0:63];
  logic       busy_log [0:63];
  logic [7:0] bytes_q  [0:2];

  scrambler_ctrl dut (
    .clk3         (clk3),
    .rst          (rst),
    .start        (start),
    .frame_len    (frame_len),
    .seed_sel     (seed_sel),
    .seed_in      (seed_in),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .lfsr_load    (lfsr_load),
    .lfsr_seed    (lfsr_seed),
    .lfsr_en      (lfsr_en),
    .ser_bit      (ser_bit),
    .ser_en       (ser_en),
    .busy         (busy),
    .done         (done),
`ifdef SCR_ABORT_EN
    .abort        (abort),
    .aborted      (aborted),
`endif
    .err_underrun (err_underrun)
  );

  always #5 clk3 = ~clk3;

  task automatic step();
    @(posedge clk3);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame request and logs n cycles. in_valid is low for cycles
  // gap_lo..gap_hi; start is re-pulsed during cycle poke (0 = never).
  task automatic run_frame(input int n, input logic [15:0] len, input logic ssel,
                           input logic [6:0] sin, input int gap_lo, input int gap_hi,
                           input int poke, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2);
    int  idx;
    logic hs;
    bytes_q[0] = b0;
    bytes_q[1] = b1;
    bytes_q[2] = b2;
    idx        = 0;
    frame_len  = len;
    seed_sel   = ssel;
    seed_in    = sin;
    in_data    = b0;
    in_valid   = 1'b1;
    start      = 1'b1;
    for (int s = 1; s <= n; s++) begin
      hs = in_valid && in_ready;
      step();
      start    = (s == poke);
      in_valid = !((s >= gap_lo) && (s <= gap_hi));
      if (hs && (idx < 2)) begin
        idx++;
        in_data = bytes_q[idx];
      end
      en_log[s]   = ser_en;
      bit_log[s]  = ser_bit;
      done_log[s] = done;
      load_log[s] = lfsr_load;
      seed_log[s] = lfsr_seed;
      rdy_log[s]  = in_ready;
      err_log[s]  = err_underrun;
      busy_log[s] = busy;
    end
    start = 1'b0;
  endtask

  // Rebuilds an LSB-first word from cnt logged bits starting at cycle from.
  function automatic logic [31:0] stream(input int from, input int cnt);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < cnt; i++) w[i] = bit_log[from + i];
    return w;
  endfunction

  function automatic int count_en(input int a, input int b);
    int c;
    c = 0;
    for (int i = a; i <= b; i++) if (en_log[i]) c++;
    return c;
  endfunction

  function automatic int count_done(input int a, input int b);
    int c;
    c = 0;
    for (int i = a; i <= b; i++) if (done_log[i]) c++;
    return c;
  endfunction

  function automatic int count_load(input int a, input int b);
    int c;
    c = 0;
    for (int i = a; i <= b; i++) if (load_log[i]) c++;
    return c;
  endfunction

  initial begin
    int dcnt;

    // Reset state
    step();
    step();
    check("reset_outputs",
          {busy, done, in_ready, lfsr_load, lfsr_en, ser_en, ser_bit, err_underrun, lfsr_seed},
          32'h0);
    rst = 1'b0;
    step();

    // Single byte A5 with default seed
    run_frame(13, 16'd1, 1'b0, 7'h00, 0, 0, 0, 8'hA5, 8'h00, 8'h00);
    check("t1_load_c1", load_log[1], 1'b1);
    check("t1_seed_c1", seed_log[1], 7'h5D);
    check("t1_load_once", count_load(1, 13), 1);
    check("t1_ready_c2", rdy_log[2], 1'b1);
    check("t1_en_before", en_log[2], 1'b0);
    check("t1_bits", stream(3, 8), 32'hA5);
    check("t1_en_count", count_en(1, 13), 8);
    check("t1_done_c11", done_log[11], 1'b1);
    check("t1_done_once", count_done(1, 13), 1);
    check("t1_busy_after", busy_log[12], 1'b0);
    check("t1_underrun", err_log[13], 1'b0);

    // Three continuous bytes; a stray start mid-frame must be ignored
    run_frame(30, 16'd3, 1'b0, 7'h00, 0, 0, 5, 8'h01, 8'h80, 8'hFF);
    check("t2_en_count", count_en(1, 30), 24);
    check("t2_en_span", count_en(3, 26), 24);
    check("t2_bits", stream(3, 24), 32'h00FF8001);
    check("t2_ready_bit7", rdy_log[10], 1'b1);
    check("t2_done_c27", done_log[27], 1'b1);
    check("t2_done_once", count_done(1, 30), 1);
    check("t2_load_once", count_load(1, 30), 1);
    check("t2_underrun", err_log[30], 1'b0);

    // Two bytes with a 5-cycle source stall between them
    run_frame(27, 16'd2, 1'b0, 7'h00, 10, 14, 0, 8'h3C, 8'hC3, 8'h00);
    check("t3_byte1", stream(3, 8), 32'h3C);
    check("t3_gap_en", count_en(11, 15), 0);
    check("t3_byte2", stream(16, 8), 32'hC3);
    check("t3_en_count", count_en(1, 27), 16);
    check("t3_err_before", err_log[10], 1'b0);
    check("t3_err_set", err_log[11], 1'b1);
    check("t3_done_c24", done_log[24], 1'b1);
    check("t3_done_once", count_done(1, 27), 1);
    step();
    step();
    check("t3_err_sticky", err_underrun, 1'b1);

    // Zero-length frame
    run_frame(4, 16'd0, 1'b0, 7'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    check("t4_done_c1", done_log[1], 1'b1);
    check("t4_busy_c1", busy_log[1], 1'b1);
    check("t4_busy_c2", busy_log[2], 1'b0);
    check("t4_no_load", count_load(1, 4), 0);
    check("t4_no_en", count_en(1, 4), 0);
    check("t4_done_once", count_done(1, 4), 1);

    // Reset during bit 4 of byte 2, then restart with an external seed
    run_frame(15, 16'd2, 1'b0, 7'h00, 0, 0, 0, 8'h55, 8'hAA, 8'h00);
    check("t5_bits_b1", stream(3, 8), 32'h55);
    check("t5_bit4_b2", {en_log[15], bit_log[15], bit_log[14]}, 3'b101);
    rst = 1'b1;
    step();
    check("t5_rst_outputs",
          {busy, done, in_ready, lfsr_load, lfsr_en, ser_en, ser_bit, err_underrun, lfsr_seed},
          32'h0);
    rst      = 1'b0;
    in_valid = 1'b0;
    dcnt     = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || busy) dcnt++;
    end
    check("t5_quiet_after_rst", dcnt, 0);
    run_frame(13, 16'd1, 1'b1, 7'h12, 0, 0, 0, 8'h96, 8'h00, 8'h00);
    check("t5_seed_ext", {load_log[1], seed_log[1]}, {1'b1, 7'h12});
    check("t5_new_bits", stream(3, 8), 32'h96);
    check("t5_new_done", done_log[11], 1'b1);

`ifdef SCR_ABORT_EN
    // Abort mid-SHIFT together with a start that must lose to it
    run_frame(6, 16'd2, 1'b0, 7'h00, 0, 0, 0, 8'h11, 8'h22, 8'h00);
    check("t6_shifting", en_log[6], 1'b1);
    abort = 1'b1;
    start = 1'b1;
    step();
    check("t6_abort_state", {aborted, busy, ser_en, in_ready, done}, 5'b10000);
    abort    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    step();
    check("t6_aborted_pulse", {aborted, busy}, 2'b00);
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done || ser_en) dcnt++;
    end
    check("t6_no_done", dcnt, 0);
    abort = 1'b1;
    step();
    check("t6_abort_idle", {aborted, busy}, 2'b00);
    abort = 1'b0;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
